// File: rtl/prog_binary_counter_if.sv
// Control/status bundle for prog_binary_counter: the block under control
// connects through the slave modport, the controller through the master modport.
interface prog_binary_counter_if #(
  parameter int WIDTH      = 6,
  parameter int PRESCALE_W = 4
);
  logic                  enable;
  logic                  load;
  logic [WIDTH-1:0]      load_value;
  logic                  up_down;
  logic                  saturate;
  logic                  one_shot;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      compare_value;
  logic                  clear_flags;
  logic [WIDTH-1:0]      count;
  logic                  tick;
  logic                  terminal;
  logic                  match;
  logic                  overflow;
  logic                  done;

  modport master (
    output enable, load, load_value, up_down, saturate, one_shot,
           prescale, compare_value, clear_flags,
    input  count, tick, terminal, match, overflow, done
  );

  modport slave (
    input  enable, load, load_value, up_down, saturate, one_shot,
           prescale, compare_value, clear_flags,
    output count, tick, terminal, match, overflow, done
  );
endinterface

// File: rtl/prog_binary_counter.sv
// Prescaled up/down event counter with load, wrap/saturate/one-shot terminal
// handling, compare match and a sticky overflow flag.
module prog_binary_counter #(
  parameter int WIDTH      = 6,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  prog_binary_counter_if.slave  bus
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  localparam logic [WIDTH-1:0]      CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]      CNT_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]      CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PRE_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  tick_q, tick_d;
  logic                  ovf_q, ovf_d;
  logic [0:0]            state_q, state_d;
  logic                  terminal_s;
  logic                  ovf_set_s;

  assign terminal_s = bus.up_down ? (count_q == CNT_ONES) : (count_q == CNT_ZERO);

  // Next-state logic: load beats a step, and a step at terminal raises overflow.
  always_comb begin
    count_d   = count_q;
    presc_d   = presc_q;
    tick_d    = 1'b0;
    state_d   = state_q;
    ovf_set_s = 1'b0;
    if (bus.load) begin
      count_d = bus.load_value;
      presc_d = PRE_ZERO;
      state_d = ST_RUN;
    end else if ((state_q == ST_RUN) && bus.enable) begin
      if (presc_q == bus.prescale) begin
        presc_d = PRE_ZERO;
        tick_d  = 1'b1;
        if (terminal_s) begin
          ovf_set_s = 1'b1;
          if (bus.one_shot) begin
            state_d = ST_DONE;
          end else if (bus.saturate) begin
            count_d = count_q;
          end else begin
            count_d = bus.up_down ? CNT_ZERO : CNT_ONES;
          end
        end else begin
          count_d = bus.up_down ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
        end
      end else begin
        presc_d = presc_q + PRE_ONE;
      end
    end else begin
      presc_d = presc_q;
    end

    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (bus.clear_flags) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= CNT_ZERO;
      presc_q <= PRE_ZERO;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.tick     = tick_q;
  assign bus.overflow = ovf_q;
  assign bus.done     = (state_q == ST_DONE);
  assign bus.terminal = terminal_s;
  assign bus.match    = (count_q == bus.compare_value);

endmodule
